// File: rtl/serial_word_receiver.sv
// serial_word_receiver: MSB-first serial deframer into a word FIFO with gap timeout; SERIAL_RX_PARITY_EN adds an even-parity bit
module serial_word_receiver #(
    parameter int DEPTH   = 4,
    parameter int GAP_MAX = 3
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   ser_in,
    input  logic                   in_valid,
    output logic [7:0]             out_data,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [$clog2(DEPTH):0] fill,
    output logic                   frame_err,
    output logic                   overflow,
    output logic                   par_err
);
    localparam int AW = $clog2(DEPTH);
    localparam int GW = $clog2(GAP_MAX + 1);
`ifdef SERIAL_RX_PARITY_EN
    localparam int WBITS = 9;
`else
    localparam int WBITS = 8;
`endif
    typedef enum logic {IDLE, RECV} state_t;
    state_t        state_q, state_d;
    logic [7:0]    shift_q, shift_d;
    logic [3:0]    bit_cnt_q, bit_cnt_d;
    logic [GW-1:0] gap_q, gap_d;
    logic          frame_err_q, frame_err_d;
    logic          par_err_q, par_err_d;
    logic          overflow_q, overflow_d;
    logic [7:0]    head_q, head_d;
    logic [AW:0]   count_q, count_d;
    logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d, rd_nxt;
    logic [7:0]    mem_q [DEPTH];
    logic          word_done, push, push_ok, pop, full;
    logic [7:0]    word;
    always_comb begin
        state_d     = state_q;
        shift_d     = shift_q;
        bit_cnt_d   = bit_cnt_q;
        gap_d       = gap_q;
        word_done   = 1'b0;
        frame_err_d = 1'b0;
        if (state_q == IDLE) begin
            bit_cnt_d = '0;
            gap_d     = '0;
            if (in_valid) begin
                shift_d   = {shift_q[6:0], ser_in};
                bit_cnt_d = 4'd1;
                state_d   = RECV;
            end
        end else if (in_valid) begin
            shift_d   = {shift_q[6:0], ser_in};
            bit_cnt_d = bit_cnt_q + 4'd1;
            gap_d     = '0;
            if (bit_cnt_q == 4'(WBITS - 1)) begin
                word_done = 1'b1;
                bit_cnt_d = '0;
                state_d   = IDLE;
            end
        end else if (gap_q == GW'(GAP_MAX - 1)) begin
            frame_err_d = 1'b1;
            bit_cnt_d   = '0;
            gap_d       = '0;
            state_d     = IDLE;
        end else begin
            gap_d = gap_q + GW'(1);
        end
    end
`ifdef SERIAL_RX_PARITY_EN
    // the parity bit is still on ser_in, so shift_q already holds all 8 data bits
    assign word      = shift_q;
    assign push      = word_done && !(^{shift_q, ser_in});
    assign par_err_d = word_done && (^{shift_q, ser_in});
`else
    assign word      = {shift_q[6:0], ser_in};
    assign push      = word_done;
    assign par_err_d = 1'b0;
`endif
    assign out_valid = count_q != '0;
    assign full      = count_q == (AW + 1)'(DEPTH);
    assign pop       = out_valid && out_ready;
    assign push_ok   = push && (!full || pop);
    assign rd_nxt    = rd_ptr_q + AW'(1);
    always_comb begin
        count_d    = count_q + (AW + 1)'(push_ok) - (AW + 1)'(pop);
        wr_ptr_d   = push_ok ? wr_ptr_q + AW'(1) : wr_ptr_q;
        rd_ptr_d   = pop ? rd_nxt : rd_ptr_q;
        overflow_d = overflow_q || (push && full && !pop);
        // head is registered: next stored entry, else the incoming word if it becomes head, else hold
        head_d     = (pop && count_q > (AW + 1)'(1)) ? mem_q[rd_nxt] :
                     (push_ok && (count_q == '0 || pop)) ? word : head_q;
    end
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= IDLE;
            shift_q     <= '0;
            bit_cnt_q   <= '0;
            gap_q       <= '0;
            frame_err_q <= 1'b0;
            par_err_q   <= 1'b0;
            overflow_q  <= 1'b0;
            head_q      <= '0;
            count_q     <= '0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
        end else begin
            state_q     <= state_d;
            shift_q     <= shift_d;
            bit_cnt_q   <= bit_cnt_d;
            gap_q       <= gap_d;
            frame_err_q <= frame_err_d;
            par_err_q   <= par_err_d;
            overflow_q  <= overflow_d;
            head_q      <= head_d;
            count_q     <= count_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            if (push_ok) mem_q[wr_ptr_q] <= word;
        end
    end
    assign out_data  = head_q;
    assign fill      = count_q;
    assign frame_err = frame_err_q;
    assign overflow  = overflow_q;
    assign par_err   = par_err_q;
endmodule

// File: tb/tb_serial_word_receiver.sv
// tb_serial_word_receiver: directed and random stimulus against a queue-based word/FIFO reference
module tb_serial_word_receiver;
    localparam int DEPTH   = 4;
    localparam int GAP_MAX = 3;
`ifdef SERIAL_RX_PARITY_EN
    localparam int WB = 9;
`else
    localparam int WB = 8;
`endif
    logic clk = 1'b0, rst = 1'b0, ser_in = 1'b0, in_valid = 1'b0, out_ready = 1'b0;
    logic [7:0] out_data;
    logic out_valid, frame_err, overflow, par_err;
    logic [$clog2(DEPTH):0] fill;
    int total = 0, bad = 0;
    logic [7:0] q[$];
    bit cur[$];
    int idle = 0;
    bit m_ovf = 0, m_ferr = 0, m_perr = 0;
    logic [7:0] m_data = 8'h00;

    serial_word_receiver #(.DEPTH(DEPTH), .GAP_MAX(GAP_MAX)) dut (
        .clk(clk), .rst(rst), .ser_in(ser_in), .in_valid(in_valid),
        .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
        .fill(fill), .frame_err(frame_err), .overflow(overflow), .par_err(par_err)
    );

    always #5 clk = ~clk;

    function automatic void model_reset();
        q.delete();
        cur.delete();
        idle = 0;
        m_ovf = 0;
        m_ferr = 0;
        m_perr = 0;
        m_data = 8'h00;
    endfunction

    // one clock of behaviour: collect bits into a word, then apply pop-before-push FIFO rules
    function automatic void model_cycle(input bit v, input bit b, input bit r);
        bit pop = (q.size() > 0) && r;
        bit have = 0;
        bit p = 0;
        logic [7:0] w = 8'h00;
        m_ferr = 0;
        m_perr = 0;
        if (v) begin
            cur.push_back(b);
            idle = 0;
            if (cur.size() == WB) begin
                for (int i = 0; i < 8; i++) w = {w[6:0], cur[i]};
                foreach (cur[i]) p ^= cur[i];
                have = (WB == 8) || (p == 0);
                m_perr = !have;
                cur.delete();
            end
        end else if (cur.size() > 0) begin
            idle++;
            if (idle == GAP_MAX) begin
                cur.delete();
                idle = 0;
                m_ferr = 1;
            end
        end
        if (pop) void'(q.pop_front());
        if (have) begin
            if (q.size() < DEPTH) q.push_back(w);
            else m_ovf = 1;
        end
        if (q.size() > 0) m_data = q[0];
    endfunction

    task automatic chk(input string name, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", name, obs, exp);
        end
    endtask

    task automatic check_all(input string tag);
        chk({tag, ".out_valid"}, 32'(out_valid), 32'(q.size() != 0));
        chk({tag, ".out_data"}, 32'(out_data), 32'(m_data));
        chk({tag, ".fill"}, 32'(fill), 32'(q.size()));
        chk({tag, ".frame_err"}, 32'(frame_err), 32'(m_ferr));
        chk({tag, ".overflow"}, 32'(overflow), 32'(m_ovf));
        chk({tag, ".par_err"}, 32'(par_err), 32'(m_perr));
    endtask

    task automatic step(input bit v, input bit b, input bit r);
        in_valid = v;
        ser_in = b;
        out_ready = r;
        model_cycle(v, b, r);
        @(posedge clk);
        #1;
        check_all("step");
    endtask

    task automatic send_word(input logic [7:0] w, input bit r_last, input int gap_at = -1,
                             input int gap_len = 0, input bit bad_par = 0);
        logic [8:0] bits = {w, (^w) ^ bad_par};
        for (int i = 0; i < WB; i++) begin
            if (i == gap_at) repeat (gap_len) step(1'b0, 1'b0, 1'b0);
            step(1'b1, bits[8 - i], (i == WB - 1) ? r_last : 1'b0);
        end
    endtask

    task automatic pop_expect(input logic [7:0] v);
        chk("pop_head", 32'(out_data), 32'(v));
        step(1'b0, 1'b0, 1'b1);
    endtask

    // reset lands between clock edges, then is released between edges
    task automatic do_reset();
        #2;
        rst = 1'b0;
        in_valid = 1'b0;
        out_ready = 1'b0;
        model_reset();
        #1;
        chk("rst_now.out_valid", 32'(out_valid), 32'd0);
        chk("rst_now.fill", 32'(fill), 32'd0);
        chk("rst_now.overflow", 32'(overflow), 32'd0);
        check_all("rst_now");
        @(posedge clk);
        #1;
        check_all("rst_hold");
        #2;
        rst = 1'b1;
    endtask

    initial begin
        repeat (2) @(posedge clk);
        #1;
        chk("reset.out_data", 32'(out_data), 32'h00);
        check_all("reset");
        #2;
        rst = 1'b1;

        send_word(8'hA5, 1'b0);
        chk("a5.out_valid", 32'(out_valid), 32'd1);
        chk("a5.out_data", 32'(out_data), 32'hA5);
        chk("a5.fill", 32'(fill), 32'd1);
        step(1'b0, 1'b0, 1'b1);
        chk("a5_pop.out_valid", 32'(out_valid), 32'd0);
        chk("a5_pop.fill", 32'(fill), 32'd0);

        for (int i = 1; i <= 5; i++) send_word(8'(i), 1'b0);
        chk("full.fill", 32'(fill), 32'd4);
        chk("full.overflow", 32'(overflow), 32'd1);
        for (int i = 1; i <= 4; i++) pop_expect(8'(i));
        chk("drained.fill", 32'(fill), 32'd0);

        do_reset();
        for (int i = 1; i <= 4; i++) send_word(8'(i), 1'b0);
        send_word(8'hC3, 1'b1);
        chk("pushpop.fill", 32'(fill), 32'd4);
        chk("pushpop.overflow", 32'(overflow), 32'd0);
        pop_expect(8'h02);
        pop_expect(8'h03);
        pop_expect(8'h04);
        pop_expect(8'hC3);
        chk("pushpop_drained.fill", 32'(fill), 32'd0);

        for (int i = 0; i < 5; i++) step(1'b1, 1'($urandom_range(0, 1)), 1'b0);
        repeat (3) step(1'b0, 1'b0, 1'b0);
        chk("gap.frame_err", 32'(frame_err), 32'd1);
        step(1'b0, 1'b0, 1'b0);
        chk("gap.frame_err_once", 32'(frame_err), 32'd0);
        chk("gap.no_push", 32'(fill), 32'd0);
        send_word(8'h3C, 1'b0);
        pop_expect(8'h3C);
        send_word(8'h96, 1'b0, 3, 2);
        chk("gap2.frame_err", 32'(frame_err), 32'd0);
        pop_expect(8'h96);

        send_word(8'h11, 1'b0);
        send_word(8'h22, 1'b0);
        for (int i = 0; i < 4; i++) step(1'b1, 1'b1, 1'b0);
        chk("mid.fill", 32'(fill), 32'd2);
        do_reset();
        send_word(8'hE7, 1'b0);
        chk("fresh.fill", 32'(fill), 32'd1);
        pop_expect(8'hE7);

`ifdef SERIAL_RX_PARITY_EN
        send_word(8'h5A, 1'b0);
        chk("par_ok.out_data", 32'(out_data), 32'h5A);
        chk("par_ok.fill", 32'(fill), 32'd1);
        send_word(8'h5B, 1'b0, -1, 0, 1'b1);
        chk("par_bad.par_err", 32'(par_err), 32'd1);
        chk("par_bad.fill", 32'(fill), 32'd1);
        pop_expect(8'h5A);
`endif

        for (int n = 0; n < 600; n++) begin
            if ($urandom_range(0, 19) == 0) repeat ($urandom_range(1, 4)) step(1'b0, 1'b0, 1'($urandom_range(0, 1)));
            step(1'($urandom_range(0, 9) < 8), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 2) == 0));
            if (n == 300) do_reset();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
